ebus_diag_reader: RTL and testbench

- Diagnostic-side initiator for the EBUS data bus that the EDP slices drive.
- Asserts the diag read-function strobe and the 3-bit diag select (diag_04/05/06) on command from the front end.
- Waits a programmable settle time, samples the 36-bit EBUS data word and returns it over a four-phase req/ack handshake.
- Sits between the front-end diagnostic port and the EBUS, alongside the CTL/APR diag decode.

---
 rtl/ebus_diag_reader_if.sv | 27 ++
 rtl/ebus_diag_reader.sv | 167 ++++++++++++++++
 tb/tb_ebus_diag_reader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ebus_diag_reader_if.sv
// ebus_diag_reader_if: front-end diagnostic read handshake bundle.
// The master side (front end) raises fe_req_h with a select code. The slave side
// (ebus_diag_reader) returns the captured EBUS word with fe_ack_h and reports
// activity on fe_busy_h.
interface ebus_diag_reader_if;
    logic        fe_req_h;
    logic [2:0]  fe_sel_h;
    logic        fe_ack_h;
    logic [35:0] fe_data_h;
    logic        fe_busy_h;

    modport master (
        output fe_req_h,
        output fe_sel_h,
        input  fe_ack_h,
        input  fe_data_h,
        input  fe_busy_h
    );

    modport slave (
        input  fe_req_h,
        input  fe_sel_h,
        output fe_ack_h,
        output fe_data_h,
        output fe_busy_h
    );
endinterface

// File: rtl/ebus_diag_reader.sv
// ebus_diag_reader: diagnostic-side EBUS read initiator.
// A front-end request latches the diag select code and raises the read-function
// strobe one clock later. After SETTLE_CYC clocks the reader samples the 36-bit
// EBUS word, holds the strobe for HOLD_CYC more clocks, and then returns the word
// over a four-phase req/ack handshake.
// Optional feature: define EBUS_PARITY_EN to enable a sticky odd-parity check of
// the sampled word against ebus_dp_h. Without the macro, parity_err_h is tied low.
module ebus_diag_reader #(
    parameter int SETTLE_CYC = 4,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk_diag_h,
    input  logic              diag_reset_l,
    ebus_diag_reader_if.slave fe,
    output logic              diag_read_func_12x_h,
    output logic              diag_04_a_h,
    output logic              diag_05_a_h,
    output logic              diag_06_a_h,
    input  logic [35:0]       ebus_d_h,
    input  logic              ebus_dp_h,
    output logic              parity_err_h
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SETTLE,
        SAMPLE,
        HOLD,
        ACK
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic [2:0]  sel_q;
    logic        strobe_q;
    logic        ack_q;
    logic        busy_q;
    logic [35:0] data_q;
    logic        accept_now;
    logic        capture_now;

    assign accept_now  = (state == IDLE) && fe.fe_req_h;
    assign capture_now = (state == SETTLE) && (count == 4'd1);

    assign fe.fe_ack_h          = ack_q;
    assign fe.fe_data_h         = data_q;
    assign fe.fe_busy_h         = busy_q;
    assign diag_read_func_12x_h = strobe_q;
    assign diag_04_a_h          = sel_q[2];
    assign diag_05_a_h          = sel_q[1];
    assign diag_06_a_h          = sel_q[0];

    // Read sequencer: select, strobe, settle, sample, hold, then handshake the word back.
    always_ff @(posedge clk_diag_h or negedge diag_reset_l) begin
        if (!diag_reset_l) begin
            state    <= IDLE;
            count    <= 4'd0;
            sel_q    <= 3'b000;
            strobe_q <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= 36'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fe.fe_req_h) begin
                        sel_q  <= fe.fe_sel_h;
                        count  <= 4'(SETTLE_CYC);
                        busy_q <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (!fe.fe_req_h) begin
                        state    <= IDLE;
                        strobe_q <= 1'b0;
                        sel_q    <= 3'b000;
                        busy_q   <= 1'b0;
                    end else begin
                        strobe_q <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (capture_now) begin
                        data_q <= ebus_d_h;
                    end
                    if (!fe.fe_req_h) begin
                        state    <= IDLE;
                        strobe_q <= 1'b0;
                        sel_q    <= 3'b000;
                        busy_q   <= 1'b0;
                    end else if (capture_now) begin
                        state <= SAMPLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                SAMPLE: begin
                    count <= 4'(HOLD_CYC);
                    if (HOLD_CYC == 0) begin
                        strobe_q <= 1'b0;
                        sel_q    <= 3'b000;
                        ack_q    <= 1'b1;
                        state    <= ACK;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!fe.fe_req_h) begin
                        state    <= IDLE;
                        strobe_q <= 1'b0;
                        sel_q    <= 3'b000;
                        busy_q   <= 1'b0;
                    end else if (count <= 4'd1) begin
                        strobe_q <= 1'b0;
                        sel_q    <= 3'b000;
                        ack_q    <= 1'b1;
                        state    <= ACK;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ACK: begin
                    if (!fe.fe_req_h) begin
                        ack_q  <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    strobe_q <= 1'b0;
                    sel_q    <= 3'b000;
                    ack_q    <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef EBUS_PARITY_EN
    logic perr_q;

    // Sticky odd-parity check of the sampled word; a newly accepted request starts clean.
    always_ff @(posedge clk_diag_h or negedge diag_reset_l) begin
        if (!diag_reset_l) begin
            perr_q <= 1'b0;
        end else if (accept_now) begin
            perr_q <= 1'b0;
        end else if (capture_now && !(^{ebus_d_h, ebus_dp_h})) begin
            perr_q <= 1'b1;
        end
    end

    assign parity_err_h = perr_q;
`else
    logic unused_dp;
    logic unused_accept;
    assign unused_dp     = ebus_dp_h;
    assign unused_accept = accept_now;
    assign parity_err_h  = 1'b0;
`endif

endmodule

// File: tb/tb_ebus_diag_reader.sv
// tb_ebus_diag_reader: self-checking bench for ebus_diag_reader.
// The expected response of each read is derived from the cycle offsets after the
// accepting edge. The sample lands at SETTLE+1 and the ack at SETTLE+2+HOLD. The
// EBUS word changes randomly every clock, so the captured value pins the sample
// edge exactly.
module tb_ebus_diag_reader;
    localparam int SETTLE      = 4;
    localparam int HOLD        = 1;
    localparam int SAMPLE_EDGE = SETTLE + 1;
    localparam int ACK_EDGE    = SETTLE + 2 + HOLD;

    logic        clk_diag_h = 1'b0;
    logic        diag_reset_l;
    logic        diag_read_func_12x_h;
    logic        diag_04_a_h;
    logic        diag_05_a_h;
    logic        diag_06_a_h;
    logic [35:0] ebus_d;
    logic        ebus_dp;
    logic        parity_err_h;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [35:0] exp_data;
    logic        exp_perr;

    ebus_diag_reader_if fe ();

    ebus_diag_reader #(
        .SETTLE_CYC (SETTLE),
        .HOLD_CYC   (HOLD)
    ) dut (
        .clk_diag_h           (clk_diag_h),
        .diag_reset_l         (diag_reset_l),
        .fe                   (fe),
        .diag_read_func_12x_h (diag_read_func_12x_h),
        .diag_04_a_h          (diag_04_a_h),
        .diag_05_a_h          (diag_05_a_h),
        .diag_06_a_h          (diag_06_a_h),
        .ebus_d_h             (ebus_d),
        .ebus_dp_h            (ebus_dp),
        .parity_err_h         (parity_err_h)
    );

    always #5 clk_diag_h = ~clk_diag_h;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk_diag_h);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic busy, input logic strobe,
                            input logic [2:0] sel, input logic ack);
        checkOutput({tag, " busy"},   36'(fe.fe_busy_h), 36'(busy));
        checkOutput({tag, " strobe"}, 36'(diag_read_func_12x_h), 36'(strobe));
        checkOutput({tag, " sel"},    36'({diag_04_a_h, diag_05_a_h, diag_06_a_h}), 36'(sel));
        checkOutput({tag, " ack"},    36'(fe.fe_ack_h), 36'(ack));
        checkOutput({tag, " data"},   fe.fe_data_h, exp_data);
        checkOutput({tag, " perr"},   36'(parity_err_h), 36'(exp_perr));
    endtask

    // Present the EBUS word that the next rising edge will see.
    task automatic set_ebus(input bit fixed, input logic [35:0] fd, input logic fdp);
        if (fixed) begin
            ebus_d  = fd;
            ebus_dp = fdp;
        end else begin
            ebus_d  = 36'({$urandom, $urandom});
            ebus_dp = 1'($urandom);
        end
    endtask

    function automatic bit even_ones(input logic [35:0] d, input logic dp);
        return ($countones({d, dp}) % 2) == 0;
    endfunction

    // One complete read. abort_edge = 0 means no abort. Otherwise req is seen low on that edge.
    task automatic applyStimulus(input logic [2:0] sel, input int abort_edge, input bit fixed,
                                 input logic [35:0] fd, input logic fdp,
                                 input int ack_hold, input int idle_gap);
        bit aborted = 0;
        fe.fe_req_h = 1'b1;
        fe.fe_sel_h = sel;
        set_ebus(fixed, fd, fdp);
        tick();
`ifdef EBUS_PARITY_EN
        exp_perr = 1'b0;
`endif
        checkAll("accept", 1'b1, 1'b0, sel, 1'b0);
        fe.fe_sel_h = ~sel;
        for (int n = 1; n <= ACK_EDGE; n++) begin
            if (n == abort_edge) fe.fe_req_h = 1'b0;
            set_ebus(fixed, fd, fdp);
            if (n == SAMPLE_EDGE) begin
                exp_data = ebus_d;
`ifdef EBUS_PARITY_EN
                if (even_ones(ebus_d, ebus_dp)) exp_perr = 1'b1;
`endif
            end
            tick();
            if (n == abort_edge) begin
                checkAll($sformatf("abort@%0d", n), 1'b0, 1'b0, 3'b000, 1'b0);
                aborted = 1;
                break;
            end else if (n == ACK_EDGE) begin
                checkAll("ack", 1'b1, 1'b0, 3'b000, 1'b1);
            end else begin
                checkAll($sformatf("run@%0d", n), 1'b1, 1'b1, sel, 1'b0);
            end
        end
        if (!aborted) begin
            for (int h = 0; h < ack_hold; h++) begin
                set_ebus(fixed, fd, fdp);
                tick();
                checkAll("ackhold", 1'b1, 1'b0, 3'b000, 1'b1);
            end
            fe.fe_req_h = 1'b0;
            set_ebus(fixed, fd, fdp);
            tick();
            checkAll("release", 1'b0, 1'b0, 3'b000, 1'b0);
        end
        for (int g = 0; g < idle_gap; g++) begin
            set_ebus(fixed, fd, fdp);
            tick();
            checkAll("idle", 1'b0, 1'b0, 3'b000, 1'b0);
        end
    endtask

    initial begin
        int k;
        exp_data     = 36'd0;
        exp_perr     = 1'b0;
        diag_reset_l = 1'b0;
        fe.fe_req_h  = 1'b1;
        fe.fe_sel_h  = 3'b111;
        set_ebus(0, 36'd0, 1'b0);
        $display("[TB] reset held with request high");
        tick();
        tick();
        checkAll("reset", 1'b0, 1'b0, 3'b000, 1'b0);

        // Reset release with req still high: accepted on the next edge.
        diag_reset_l = 1'b1;
        $display("[TB] basic read sel=101");
        applyStimulus(3'b101, 0, 1, 36'o123456701234, 1'b0, 1, 0);
        checkOutput("basic word", fe.fe_data_h, 36'o123456701234);

        $display("[TB] back-to-back read, one idle gap");
        applyStimulus(3'b010, 0, 0, 36'd0, 1'b0, 0, 1);

        $display("[TB] abort during settle");
        applyStimulus(3'b011, 3, 0, 36'd0, 1'b0, 0, 1);
        applyStimulus(3'b110, 0, 0, 36'd0, 1'b0, 0, 0);

        $display("[TB] abort on the sample edge");
        applyStimulus(3'b001, SAMPLE_EDGE, 0, 36'd0, 1'b0, 0, 1);

        $display("[TB] parity patterns");
        applyStimulus(3'b100, 0, 1, 36'o1, 1'b0, 0, 1);
        applyStimulus(3'b100, 0, 1, 36'o3, 1'b0, 2, 1);
        applyStimulus(3'b001, 0, 1, 36'o7, 1'b0, 0, 1);

        $display("[TB] randomized reads");
        for (int i = 0; i < 24; i++) begin
            k = 0;
            if ($urandom_range(2, 0) == 0) begin
                k = int'($urandom_range(ACK_EDGE, 1));
                if (k == SAMPLE_EDGE + 1) k = SAMPLE_EDGE;
            end
            applyStimulus(3'($urandom), k, 0, 36'd0, 1'b0,
                          int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
        end

        $display("[TB] asynchronous reset mid-read");
        fe.fe_req_h = 1'b1;
        fe.fe_sel_h = 3'b111;
        tick();
        tick();
        tick();
        checkOutput("pre-reset strobe", 36'(diag_read_func_12x_h), 36'd1);
        #2;
        diag_reset_l = 1'b0;
        #1;
        exp_data = 36'd0;
        exp_perr = 1'b0;
        checkAll("async reset", 1'b0, 1'b0, 3'b000, 1'b0);
        fe.fe_req_h = 1'b0;
        tick();
        checkAll("in reset", 1'b0, 1'b0, 3'b000, 1'b0);
        diag_reset_l = 1'b1;
        tick();
        checkAll("post reset", 1'b0, 1'b0, 3'b000, 1'b0);
        applyStimulus(3'b101, 0, 0, 36'd0, 1'b0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
